// File: rtl/fifo4_port_ctrl.sv
// Shares one unclocked 4-deep ripple FIFO between two writers and one reader.
// Generates timed strobes, synchronizes the FIFO flags and arbitrates service.
module fifo4_port_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned PULSE  = 2,
    parameter int unsigned SETTLE = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic             ack0,
    output logic             ack1,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] f_din,
    output logic             f_write,
    output logic             f_read,
    output logic             f_clr,
    input  logic [WIDTH-1:0] f_dout,
    input  logic             f_empty,
    input  logic             f_full,
    output logic             busy
);

    localparam int unsigned CntMax = (PULSE > SETTLE) ? PULSE : SETTLE;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] PulseLoad  = CntW'(PULSE - 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE - 1);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);

    // Each strobe owns a dedicated state bit so the FIFO sees a clean flop output.
    typedef enum logic [3:0] {
        StIdle     = 4'b0000,
        StWrPulse  = 4'b0001,
        StRdPulse  = 4'b0010,
        StWrSettle = 4'b0100,
        StRdSettle = 4'b1000
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              wr_sel_q, wr_sel_d;
    logic              last_wr_q, last_wr_d;
    logic              last_op_q, last_op_d;   // 1 = write, 0 = read
    logic [WIDTH-1:0]  f_din_q, f_din_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;

    logic empty_m, empty_s, full_m, full_s;

    logic wr0_ok, wr1_ok, wr_any, rd_ok, wr_pick, grant_wr, grant_rd;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            empty_m <= 1'b1;
            empty_s <= 1'b1;
            full_m  <= 1'b0;
            full_s  <= 1'b0;
        end else begin
            empty_m <= f_empty;
            empty_s <= empty_m;
            full_m  <= f_full;
            full_s  <= full_m;
        end
    end

    assign wr0_ok   = req0 && !full_s;
    assign wr1_ok   = req1 && !full_s;
    assign wr_any   = wr0_ok || wr1_ok;
    assign rd_ok    = rd_req && !empty_s;
    assign wr_pick  = (wr0_ok && wr1_ok) ? !last_wr_q : wr1_ok;
    assign grant_wr = wr_any && (!rd_ok || !last_op_q);
    assign grant_rd = rd_ok && (!wr_any || last_op_q);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wr_sel_q  <= 1'b0;
            last_wr_q <= 1'b1;
            last_op_q <= 1'b0;
            f_din_q   <= '0;
            hold_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_sel_q  <= wr_sel_d;
            last_wr_q <= last_wr_d;
            last_op_q <= last_op_d;
            f_din_q   <= f_din_d;
            hold_q    <= hold_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_sel_d  = wr_sel_q;
        last_wr_d = last_wr_q;
        last_op_d = last_op_q;
        f_din_d   = f_din_q;
        hold_d    = hold_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    state_d  = StWrPulse;
                    cnt_d    = PulseLoad;
                    wr_sel_d = wr_pick;
                    f_din_d  = wr_pick ? din1 : din0;
                end else if (grant_rd) begin
                    state_d = StRdPulse;
                    cnt_d   = PulseLoad;
                    // Capture the head word before the strobe pops it.
                    hold_d  = f_dout;
                end
            end
            StWrPulse: begin
                if (cnt_q == '0) begin
                    state_d = StWrSettle;
                    cnt_d   = SettleLoad;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StWrSettle: begin
                if (cnt_q == '0) begin
                    state_d   = StIdle;
                    last_wr_d = wr_sel_q;
                    last_op_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StRdPulse: begin
                if (cnt_q == '0) begin
                    state_d = StRdSettle;
                    cnt_d   = SettleLoad;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StRdSettle: begin
                if (cnt_q == '0) begin
                    state_d   = StIdle;
                    last_op_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CntOne;
                    // Publish the word as the final settle cycle (rd_ack) begins.
                    if (cnt_q == CntOne) begin
                        rd_data_d = hold_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        f_write = state_q[0];
        f_read  = state_q[1];
        busy    = (state_q != StIdle);
        ack0    = (state_q == StWrSettle) && (cnt_q == '0) && !wr_sel_q;
        ack1    = (state_q == StWrSettle) && (cnt_q == '0) && wr_sel_q;
        rd_ack  = (state_q == StRdSettle) && (cnt_q == '0);
        f_din   = f_din_q;
        rd_data = rd_data_q;
    end

    assign f_clr = clr;

endmodule
